dmem_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the single-port data memory. It shares the memory between the core's load/store path and an external requester (debug/DMA port), with round-robin fairness and a configurable access latency. It drives the core stall input whenever a core access is pending or in flight. It sits between the ALU/register load-store signals and data_mem.

---
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core load/store path and an
// external (debug/DMA) requester, with round-robin tie-breaking and a fixed access length.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ACC_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_load,
    input  logic              core_store,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_done,
    output logic [DATA_W-1:0] ext_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(ACC_LAT) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CORE,
        S_EXT
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last_ext;
    logic              r_ext_we;
    logic [ADDR_W-1:0] r_ext_addr;
    logic [DATA_W-1:0] r_ext_wdata;
    logic              r_ext_done;
    logic [DATA_W-1:0] r_ext_rdata;

    logic w_core_req;
    logic w_final;
    logic w_pick_core;
    logic w_pick_ext;

    assign w_core_req  = core_load | core_store;
    assign w_final     = (r_cnt == LAST_CNT);
    // On a tie the side that was not served last wins; the two picks are mutually exclusive.
    assign w_pick_core = w_core_req & (~ext_req | r_last_ext);
    assign w_pick_ext  = ext_req & (~w_core_req | ~r_last_ext);

    assign ext_gnt    = reset & (r_state == S_IDLE) & w_pick_ext;
    assign core_stall = w_core_req & ~((r_state == S_CORE) & w_final);
    assign ext_done   = r_ext_done;
    assign ext_rdata  = r_ext_rdata;

    always_comb begin
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wr_en  = 1'b0;
        mem_rd_en  = 1'b0;
        core_rdata = '0;
        case (r_state)
            S_CORE: begin
                mem_addr   = core_addr;
                mem_wdata  = core_wdata;
                mem_rd_en  = core_load & ~core_store;
                mem_wr_en  = core_store & w_final;
                core_rdata = mem_rdata;
            end
            S_EXT: begin
                mem_addr  = r_ext_addr;
                mem_wdata = r_ext_wdata;
                mem_rd_en = ~r_ext_we;
                mem_wr_en = r_ext_we & w_final;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_last_ext  <= 1'b1;
            r_ext_we    <= 1'b0;
            r_ext_addr  <= '0;
            r_ext_wdata <= '0;
            r_ext_done  <= 1'b0;
            r_ext_rdata <= '0;
        end else begin
            r_ext_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_core) begin
                        r_state    <= S_CORE;
                        r_cnt      <= '0;
                        r_last_ext <= 1'b0;
                    end else if (w_pick_ext) begin
                        r_state     <= S_EXT;
                        r_cnt       <= '0;
                        r_last_ext  <= 1'b1;
                        r_ext_we    <= ext_we;
                        r_ext_addr  <= ext_addr;
                        r_ext_wdata <= ext_wdata;
                    end
                end
                S_CORE: begin
                    if (w_final) r_state <= S_IDLE;
                    else         r_cnt   <= r_cnt + 1'b1;
                end
                S_EXT: begin
                    if (w_final) begin
                        r_state    <= S_IDLE;
                        r_ext_done <= 1'b1;
                        if (!r_ext_we) r_ext_rdata <= mem_rdata;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: three arbiters (ACC_LAT 1, 2, 3) share one stimulus; each has its own memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        core_load = 1'b0, core_store = 1'b0;
    logic [31:0] core_addr = '0, core_wdata = '0;
    logic        ext_req = 1'b0, ext_we = 1'b0;
    logic [31:0] ext_addr = '0, ext_wdata = '0;
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    int n_chk = 0;
    int n_err = 0;
    int s_a, s_b, s_c;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] core_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
        logic        core_stall, ext_gnt, ext_done, mem_wr_en, mem_rd_en;
        logic [31:0] mem [64];
        int          n_wr = 0, n_rd = 0, n_gnt = 0, n_done = 0;
        logic [31:0] last_wa = '0, last_wd = '0;

        assign mem_rdata = mem[mem_addr[7:2]];

        always @(posedge clk) begin
            if (pl_en) mem[pl_idx] <= pl_data;
            else if (mem_wr_en) mem[mem_addr[7:2]] <= mem_wdata;
            if (mem_wr_en) begin
                n_wr    <= n_wr + 1;
                last_wa <= mem_addr;
                last_wd <= mem_wdata;
            end
            if (mem_rd_en) n_rd <= n_rd + 1;
            if (ext_gnt)   n_gnt <= n_gnt + 1;
            if (ext_done)  n_done <= n_done + 1;
        end

        dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .ACC_LAT(g + 1)) u_dut (
            .clk(clk), .reset(reset),
            .core_load(core_load), .core_store(core_store),
            .core_addr(core_addr), .core_wdata(core_wdata),
            .core_rdata(core_rdata), .core_stall(core_stall),
            .ext_req(ext_req), .ext_we(ext_we),
            .ext_addr(ext_addr), .ext_wdata(ext_wdata),
            .ext_gnt(ext_gnt), .ext_done(ext_done), .ext_rdata(ext_rdata),
            .mem_addr(mem_addr), .mem_wdata(mem_wdata),
            .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata)
        );
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wait();
        core_load = 1'b0; core_store = 1'b0; ext_req = 1'b0;
        repeat (6) cyc();
    endtask

    logic exp_stall [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic exp_gnt   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        // Reset state, with requests pending and memory preload under way
        repeat (2) @(posedge clk);
        #1;
        pl_en = 1'b1; pl_idx = 6'd4; pl_data = 32'hDEADBEEF;
        core_load = 1'b1; ext_req = 1'b1;
        #1;
        chk1("rst_gnt", g_dut[0].ext_gnt, 1'b0);
        chk1("rst_stall", g_dut[0].core_stall, 1'b1);
        chk1("rst_rd_en", g_dut[2].mem_rd_en, 1'b0);
        chk1("rst_wr_en", g_dut[2].mem_wr_en, 1'b0);
        chk1("rst_done", g_dut[2].ext_done, 1'b0);
        chk32("rst_rdata", g_dut[2].ext_rdata, 32'h0);
        cyc();
        pl_en = 1'b0; core_load = 1'b0; ext_req = 1'b0; reset = 1'b1;
        repeat (2) cyc();

        // ACC_LAT=1 core load of 0x10
        s_a = g_dut[0].n_rd; s_b = g_dut[0].n_wr;
        core_load = 1'b1; core_addr = 32'h10;
        #1;
        chk1("t1_stall_idle", g_dut[0].core_stall, 1'b1);
        chk1("t1_rd_idle", g_dut[0].mem_rd_en, 1'b0);
        cyc(); #1;
        chk1("t1_stall_fin", g_dut[0].core_stall, 1'b0);
        chk32("t1_rdata", g_dut[0].core_rdata, 32'hDEADBEEF);
        chk1("t1_rd_fin", g_dut[0].mem_rd_en, 1'b1);
        cyc();
        idle_wait();
        chk32("t1_rd_count", 32'(g_dut[0].n_rd - s_a), 32'd1);
        chk32("t1_wr_count", 32'(g_dut[0].n_wr - s_b), 32'd0);

        // ACC_LAT=3 ext write then read of 0x20
        s_a = g_dut[2].n_gnt;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h20; ext_wdata = 32'hA5A5A5A5;
        #1;
        chk1("t2_gnt", g_dut[2].ext_gnt, 1'b1);
        cyc();
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = 32'hFC; ext_wdata = 32'h0;
        #1;
        chk1("t2_gnt_busy", g_dut[2].ext_gnt, 1'b0);
        chk1("t2_wr_c0", g_dut[2].mem_wr_en, 1'b0);
        chk32("t2_addr_c0", g_dut[2].mem_addr, 32'h20);
        cyc(); #1;
        chk1("t2_wr_c1", g_dut[2].mem_wr_en, 1'b0);
        cyc(); #1;
        chk1("t2_wr_c2", g_dut[2].mem_wr_en, 1'b1);
        chk32("t2_addr_c2", g_dut[2].mem_addr, 32'h20);
        chk32("t2_wdata_c2", g_dut[2].mem_wdata, 32'hA5A5A5A5);
        chk1("t2_done_early", g_dut[2].ext_done, 1'b0);
        cyc(); #1;
        chk1("t2_done", g_dut[2].ext_done, 1'b1);
        chk1("t2_wr_after", g_dut[2].mem_wr_en, 1'b0);
        cyc(); #1;
        chk1("t2_done_pulse", g_dut[2].ext_done, 1'b0);
        chk32("t2_gnt_count", 32'(g_dut[2].n_gnt - s_a), 32'd1);
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h20;
        #1;
        chk1("t2r_gnt", g_dut[2].ext_gnt, 1'b1);
        cyc();
        ext_req = 1'b0;
        repeat (3) cyc();
        #1;
        chk1("t2r_done", g_dut[2].ext_done, 1'b1);
        chk32("t2r_rdata", g_dut[2].ext_rdata, 32'hA5A5A5A5);
        idle_wait();
        chk32("t2r_rdata_held", g_dut[2].ext_rdata, 32'hA5A5A5A5);

        // Reset pulse, then both requesters held: grants must alternate, core first
        reset = 1'b0;
        #1;
        chk32("rst2_rdata", g_dut[2].ext_rdata, 32'h0);
        cyc();
        reset = 1'b1;
        cyc();
        core_load = 1'b1; core_addr = 32'h10;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h10;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc();
            #1;
            chk1($sformatf("t3_stall_%0d", i), g_dut[0].core_stall, exp_stall[i]);
            chk1($sformatf("t3_gnt_%0d", i), g_dut[0].ext_gnt, exp_gnt[i]);
        end
        idle_wait();

        // ACC_LAT=2 ext read in flight, core store issued mid-access
        s_a = g_dut[1].n_wr;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h10;
        #1;
        chk1("t4_gnt", g_dut[1].ext_gnt, 1'b1);
        cyc();
        ext_req = 1'b0;
        core_store = 1'b1; core_addr = 32'h30; core_wdata = 32'h12345678;
        #1;
        chk1("t4_stall_e0", g_dut[1].core_stall, 1'b1);
        cyc(); #1;
        chk1("t4_stall_e1", g_dut[1].core_stall, 1'b1);
        chk1("t4_wr_e1", g_dut[1].mem_wr_en, 1'b0);
        cyc(); #1;
        chk1("t4_stall_idle", g_dut[1].core_stall, 1'b1);
        chk1("t4_done", g_dut[1].ext_done, 1'b1);
        chk32("t4_ext_rdata", g_dut[1].ext_rdata, 32'hDEADBEEF);
        chk1("t4_gnt_idle", g_dut[1].ext_gnt, 1'b0);
        cyc(); #1;
        chk1("t4_stall_c0", g_dut[1].core_stall, 1'b1);
        chk1("t4_wr_c0", g_dut[1].mem_wr_en, 1'b0);
        cyc(); #1;
        chk1("t4_stall_c1", g_dut[1].core_stall, 1'b0);
        chk1("t4_wr_c1", g_dut[1].mem_wr_en, 1'b1);
        cyc();
        idle_wait();
        chk32("t4_wr_count", 32'(g_dut[1].n_wr - s_a), 32'd1);
        chk32("t4_wr_addr", g_dut[1].last_wa, 32'h30);
        chk32("t4_wr_data", g_dut[1].last_wd, 32'h12345678);

        // ACC_LAT=1 load and store together behave as a store
        s_a = g_dut[0].n_wr; s_b = g_dut[0].n_rd;
        core_load = 1'b1; core_store = 1'b1; core_addr = 32'h34; core_wdata = 32'h0BADF00D;
        #1;
        chk1("t5_stall_idle", g_dut[0].core_stall, 1'b1);
        cyc(); #1;
        chk1("t5_wr", g_dut[0].mem_wr_en, 1'b1);
        chk1("t5_rd", g_dut[0].mem_rd_en, 1'b0);
        chk1("t5_stall_fin", g_dut[0].core_stall, 1'b0);
        chk32("t5_addr", g_dut[0].mem_addr, 32'h34);
        cyc();
        idle_wait();
        chk32("t5_wr_count", 32'(g_dut[0].n_wr - s_a), 32'd1);
        chk32("t5_rd_count", 32'(g_dut[0].n_rd - s_b), 32'd0);
        chk32("t5_wr_data", g_dut[0].last_wd, 32'h0BADF00D);

        // ACC_LAT=3 ext write interrupted by reset in its 2nd BUSY cycle
        s_a = g_dut[2].n_wr; s_b = g_dut[2].n_done;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h40; ext_wdata = 32'h00000077;
        #1;
        chk1("t6_gnt", g_dut[2].ext_gnt, 1'b1);
        cyc();
        ext_req = 1'b0;
        cyc();
        reset = 1'b0;
        core_load = 1'b1; core_addr = 32'h10;
        ext_req = 1'b1; ext_we = 1'b0;
        #1;
        chk1("t6_wr_rst", g_dut[2].mem_wr_en, 1'b0);
        chk1("t6_rd_rst", g_dut[2].mem_rd_en, 1'b0);
        chk1("t6_gnt_rst", g_dut[2].ext_gnt, 1'b0);
        chk1("t6_stall_rst", g_dut[2].core_stall, 1'b1);
        chk32("t6_addr_rst", g_dut[2].mem_addr, 32'h0);
        chk32("t6_rdata_rst", g_dut[2].ext_rdata, 32'h0);
        for (int i = 0; i < 2; i++) begin
            cyc(); #1;
            chk1($sformatf("t6_wr_hold_%0d", i), g_dut[2].mem_wr_en, 1'b0);
            chk1($sformatf("t6_done_hold_%0d", i), g_dut[2].ext_done, 1'b0);
        end
        reset = 1'b1;
        #1;
        chk1("t6_gnt_rel", g_dut[2].ext_gnt, 1'b0);
        chk1("t6_stall_rel", g_dut[2].core_stall, 1'b1);
        cyc();
        ext_req = 1'b0;
        #1;
        chk1("t6_core_rd", g_dut[2].mem_rd_en, 1'b1);
        chk32("t6_core_addr", g_dut[2].mem_addr, 32'h10);
        chk1("t6_core_stall", g_dut[2].core_stall, 1'b1);
        repeat (2) cyc();
        #1;
        chk1("t6_core_fin", g_dut[2].core_stall, 1'b0);
        cyc();
        idle_wait();
        chk32("t6_wr_count", 32'(g_dut[2].n_wr - s_a), 32'd0);
        chk32("t6_done_count", 32'(g_dut[2].n_done - s_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
